// File: rtl/gpio_port_ctrl_if.sv
// Register-bus bundle between the control logic and gpio_port_ctrl:
// single-cycle writes, registered reads with a valid pulse, level IRQ back to the master.
interface gpio_port_ctrl_if #(
  parameter int WIDTH = 36
);
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             irq;

  modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid, irq);
  modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid, irq);
endinterface

// File: rtl/gpio_port_ctrl.sv
// Active driver/sampler for the GPIO header: per-pin direction/output registers,
// synchronized and debounced inputs, sticky W1C edge flags and a registered IRQ.
module gpio_port_ctrl #(
  parameter int WIDTH       = 36,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             MAX10_CLK1_50,
  input  logic             RST,
  gpio_port_ctrl_if.slave  bus,
  inout  wire  [WIDTH-1:0] GPIO
);
  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [2:0] A_DIR  = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_IER  = 3'd5;
  localparam logic [2:0] A_IEF  = 3'd6;

  logic [WIDTH-1:0] dir_r, out_r, in_r, in_d_r, rise_r, fall_r, ie_rise_r, ie_fall_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r, irq_r;

  logic [WIDTH-1:0] dir_nxt_s, out_nxt_s, ie_rise_nxt_s, ie_fall_nxt_s;
  logic [WIDTH-1:0] rise_clr_s, fall_clr_s, rise_nxt_s, fall_nxt_s, rd_mux_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign GPIO[i] = dir_r[i] ? out_r[i] : 1'bz;
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.irq      = irq_r;

  // Register write decode and flag next-state; a same-cycle edge outranks its W1C clear
  always_comb begin
    dir_nxt_s     = dir_r;
    out_nxt_s     = out_r;
    ie_rise_nxt_s = ie_rise_r;
    ie_fall_nxt_s = ie_fall_r;
    rise_clr_s    = {WIDTH{1'b0}};
    fall_clr_s    = {WIDTH{1'b0}};
    if (bus.wr_en) begin
      case (bus.addr)
        A_DIR:   dir_nxt_s     = bus.wr_data;
        A_OUT:   out_nxt_s     = bus.wr_data;
        A_RISE:  rise_clr_s    = bus.wr_data;
        A_FALL:  fall_clr_s    = bus.wr_data;
        A_IER:   ie_rise_nxt_s = bus.wr_data;
        A_IEF:   ie_fall_nxt_s = bus.wr_data;
        default: rise_clr_s    = {WIDTH{1'b0}};
      endcase
    end else begin
      rise_clr_s = {WIDTH{1'b0}};
    end
    rise_nxt_s = (rise_r & ~rise_clr_s) | (in_r & ~in_d_r);
    fall_nxt_s = (fall_r & ~fall_clr_s) | (~in_r & in_d_r);
  end

  // Read-data select from pre-write register state
  always_comb begin
    case (bus.addr)
      A_DIR:   rd_mux_s = dir_r;
      A_OUT:   rd_mux_s = out_r;
      A_IN:    rd_mux_s = in_r;
      A_RISE:  rd_mux_s = rise_r;
      A_FALL:  rd_mux_s = fall_r;
      A_IER:   rd_mux_s = ie_rise_r;
      A_IEF:   rd_mux_s = ie_fall_r;
      default: rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Input synchronizer, per-pin debounce counter and edge history
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= {CNT_W{1'b0}};
      in_r   <= {WIDTH{1'b0}};
      in_d_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= GPIO;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      in_d_r <= in_r;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_r[SYNC_STAGES-1][i] == in_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_MAX) begin
          in_r[i]  <= sync_r[SYNC_STAGES-1][i];
          cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Control registers, sticky flags, IRQ and registered read port
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      dir_r      <= {WIDTH{1'b0}};
      out_r      <= {WIDTH{1'b0}};
      rise_r     <= {WIDTH{1'b0}};
      fall_r     <= {WIDTH{1'b0}};
      ie_rise_r  <= {WIDTH{1'b0}};
      ie_fall_r  <= {WIDTH{1'b0}};
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      dir_r      <= dir_nxt_s;
      out_r      <= out_nxt_s;
      rise_r     <= rise_nxt_s;
      fall_r     <= fall_nxt_s;
      ie_rise_r  <= ie_rise_nxt_s;
      ie_fall_r  <= ie_fall_nxt_s;
      rd_valid_r <= bus.rd_en;
      irq_r      <= (|(rise_nxt_s & ie_rise_nxt_s)) | (|(fall_nxt_s & ie_fall_nxt_s));
      if (bus.rd_en) begin
        rd_data_r <= rd_mux_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Scoreboard bench for gpio_port_ctrl: stimulus pushes expectations, a negedge
// monitor pops them against read responses, IRQ and pad levels.
module tb_gpio_port_ctrl;
  localparam logic [35:0] ALL = {36{1'b1}};
  localparam int K_READ = 0, K_IRQ = 1, K_GPIO = 2, K_RDDATA = 3, K_QEMPTY = 4;

  typedef struct {
    int          kind;
    logic [35:0] mask;
    logic [35:0] exp;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] tb_en, tb_val;
  wire  [35:0] gpio;
  int          checks = 0;
  int          failures = 0;
  exp_t        rq[$];
  exp_t        pq[$];

  always #5 clk = ~clk;

  gpio_port_ctrl_if #(.WIDTH(36)) bus ();

  for (genvar i = 0; i < 36; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_port_ctrl #(.WIDTH(36), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (rst),
    .bus           (bus),
    .GPIO          (gpio)
  );

  function automatic string kname(input int k);
    case (k)
      K_READ:   return "read";
      K_IRQ:    return "irq";
      K_GPIO:   return "gpio";
      K_RDDATA: return "rd_data_hold";
      default:  return "scoreboard_drain";
    endcase
  endfunction

  // Monitor: read responses on rd_valid, level probes every negedge
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [35:0] act;
    if (bus.rd_valid) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid actual=%h required=no response", bus.rd_data);
      end else begin
        e = rq.pop_front();
        if (bus.rd_data !== e.exp) begin
          failures++;
          $display("FAIL read tag=%0d actual=%h required=%h", e.tag, bus.rd_data, e.exp);
        end
      end
    end
    while (pq.size() > 0) begin
      e = pq.pop_front();
      case (e.kind)
        K_IRQ:    act = {35'd0, bus.irq};
        K_GPIO:   act = gpio;
        K_RDDATA: act = bus.rd_data;
        default:  act = 36'(rq.size());
      endcase
      checks++;
      if ((act & e.mask) !== e.exp) begin
        failures++;
        $display("FAIL %s tag=%0d actual=%h required=%h", kname(e.kind), e.tag, act & e.mask, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [35:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [35:0] e, input int tag);
    exp_t x;
    x = '{K_READ, ALL, e, tag};
    bus.rd_en = 1'b1; bus.addr = a;
    rq.push_back(x);
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic probe(input int kind, input logic [35:0] mask, input logic [35:0] e, input int tag);
    exp_t x;
    x = '{kind, mask, e, tag};
    pq.push_back(x);
  endtask

  initial begin
    exp_t x;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 3'd0; bus.wr_data = 36'd0;
    tb_en = ALL; tb_val = 36'd0;
    tick(3);
    rst = 1'b0;
    probe(K_IRQ, 36'd1, 36'd0, 1);
    for (int a = 0; a < 8; a++) rd(3'(a), 36'd0, 10 + a);

    // Drive pins 7:0; IN follows six edges after the pad changes
    tb_en = ~36'hFF;
    wr(3'd0, 36'hFF);
    wr(3'd1, 36'hA5);
    probe(K_GPIO, 36'hFF, 36'hA5, 20);
    tick(5);
    rd(3'd2, 36'h0, 21);
    rd(3'd2, 36'hA5, 22);

    // Three-cycle glitch on pin 12 must not reach IN
    tb_val[12] = 1'b1; tick(3); tb_val[12] = 1'b0; tick(10);
    rd(3'd2, 36'hA5, 30);
    wr(3'd3, ALL);
    rd(3'd3, 36'h0, 31);

    // Pin 12 rise with IRQ_EN_R[12]
    wr(3'd5, 36'h1000);
    tb_val[12] = 1'b1;
    tick(5);
    rd(3'd2, 36'hA5, 40);
    probe(K_IRQ, 36'd1, 36'd0, 41);
    rd(3'd2, 36'h10A5, 42);
    probe(K_IRQ, 36'd1, 36'd1, 43);
    rd(3'd3, 36'h1000, 44);
    wr(3'd3, 36'h1000);
    probe(K_IRQ, 36'd1, 36'd0, 45);
    rd(3'd3, 36'h0, 46);

    // All pins back to inputs; OUT keeps its value
    wr(3'd0, 36'h0);
    tb_en = ALL;
    tick(10);
    wr(3'd4, ALL);
    rd(3'd4, 36'h0, 50);
    rd(3'd2, 36'h1000, 51);
    rd(3'd1, 36'hA5, 52);

    // W1C lands on the same edge RISE[5] sets: set wins
    tb_val[5] = 1'b1;
    tick(6);
    wr(3'd3, 36'h20);
    rd(3'd3, 36'h20, 53);
    probe(K_IRQ, 36'd1, 36'd0, 54);
    tb_val[5] = 1'b0;
    tick(8);
    probe(K_IRQ, 36'd1, 36'd0, 55);
    rd(3'd4, 36'h20, 56);
    wr(3'd6, 36'h20);
    probe(K_IRQ, 36'd1, 36'd1, 57);
    wr(3'd4, 36'h20);
    probe(K_IRQ, 36'd1, 36'd0, 58);
    rd(3'd4, 36'h0, 59);
    wr(3'd3, 36'h20);
    rd(3'd3, 36'h0, 60);

    // Same-cycle read and write of IRQ_EN_F returns the old value
    x = '{K_READ, ALL, 36'h20, 61};
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 3'd6; bus.wr_data = 36'hABC;
    rq.push_back(x);
    tick(1);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    rd(3'd6, 36'hABC, 62);
    wr(3'd7, ALL);
    rd(3'd7, 36'h0, 63);
    wr(3'd2, ALL);
    rd(3'd2, 36'h1000, 64);
    tick(2);
    probe(K_RDDATA, ALL, 36'h1000, 65);
    wr(3'd1, 36'h3C);
    rd(3'd1, 36'h3C, 66);
    rd(3'd2, 36'h1000, 67);

    // Reset mid-operation with all pins driven and flags pending
    wr(3'd5, ALL);
    wr(3'd1, ALL);
    tb_val = ALL;
    tick(10);
    probe(K_IRQ, 36'd1, 36'd1, 70);
    wr(3'd0, ALL);
    tb_en = 36'd0;
    tick(2);
    probe(K_GPIO, ALL, ALL, 71);
    rd(3'd3, ~36'h1000, 72);
    rst = 1'b1;
    tick(1);
    probe(K_IRQ, 36'd1, 36'd0, 73);
    rst = 1'b0;
    tb_en = ALL; tb_val = 36'd0;
    tick(10);
    rd(3'd0, 36'h0, 74);
    rd(3'd1, 36'h0, 75);
    rd(3'd2, 36'h0, 76);
    rd(3'd3, 36'h0, 77);
    rd(3'd4, 36'h0, 78);
    rd(3'd5, 36'h0, 79);
    probe(K_IRQ, 36'd1, 36'd0, 80);

    tick(3);
    probe(K_QEMPTY, ALL, 36'd0, 90);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
